// File: rtl/uart_rx_byte_pkg.sv
// ============================================================================
// Module   : uart_rx_byte_pkg
// Brief    : Shared defaults, FSM state encoding and baud-divisor helper for
//            the 8N1 UART receiver (and a future transmitter).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_byte_pkg;

    localparam int unsigned DEF_CLK_HZ  = 50_000_000;
    localparam int unsigned DEF_BAUD    = 115_200;
    localparam int unsigned DEF_VAL_LEN = 4;

    // Receiver frame-tracking states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Clock cycles per bit, rounded to the nearest integer
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_byte_if.sv
// ============================================================================
// Module   : uart_rx_byte_if
// Brief    : Serial line plus byte/valid/status bundle between the UART
//            receiver (master) and its environment (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_byte_if;

    logic       rx;         // async serial line, idle high
    logic [7:0] iUART;      // last correctly framed byte
    logic       ValRX;      // stretched byte-valid pulse
    logic       frame_err;  // sticky bad-stop-bit flag
    logic       busy;       // receiver not idle

    // Receiver side: consumes the line, produces the byte bus
    modport master (
        input  rx,
        output iUART,
        output ValRX,
        output frame_err,
        output busy
    );

    // Environment side: drives the line, consumes the byte bus
    modport slave (
        output rx,
        input  iUART,
        input  ValRX,
        input  frame_err,
        input  busy
    );

endinterface

`default_nettype wire

// File: rtl/uart_baud_cnt.sv
// ============================================================================
// Module   : uart_baud_cnt
// Brief    : Mod-DIV bit-period counter with synchronous clear; flags the
//            half-bit and full-bit points.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_cnt #(
    parameter int unsigned DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic half_tick,
    output logic full_tick
);

    localparam int unsigned        c_cw   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cw-1:0]    c_half = c_cw'(DIV / 2 - 1);
    localparam logic [c_cw-1:0]    c_last = c_cw'(DIV - 1);

    logic [c_cw-1:0] r_cnt;

    // Free-running bit-period counter, wraps at DIV-1 or on clear
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cw'(1);
        end
    end

    assign half_tick = (r_cnt == c_half);
    assign full_tick = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// ============================================================================
// Module   : uart_rx_byte
// Brief    : 8N1 LSB-first UART receiver feeding the telemetry answer table.
//            Produces a held data byte, a VAL_LEN-cycle valid pulse, a sticky
//            frame-error flag and a busy indication.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
    parameter int unsigned BAUD    = DEF_BAUD,
    parameter int unsigned VAL_LEN = DEF_VAL_LEN
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_byte_if.master bus
);

    localparam int unsigned     DIV           = calc_div(CLK_HZ, BAUD);
    localparam int unsigned     c_sw          = (VAL_LEN > 1) ? $clog2(VAL_LEN) : 1;
    localparam logic [c_sw-1:0] c_stretch_top = c_sw'(VAL_LEN - 1);

    // The pulse must end before the next stop sample and the half-bit point
    // must leave room for the synchroniser.
    generate
        if ((DIV < 4 * VAL_LEN) || (DIV < 8) || (VAL_LEN < 3)) begin : g_param_check
            $error("uart_rx_byte: need DIV >= 4*VAL_LEN, DIV >= 8, VAL_LEN >= 3");
        end
    endgenerate

    logic            r_sync1;
    logic            r_sync2;
    logic            w_rxs;
    logic [1:0]      r_warm;
    rx_state_e       r_state;
    rx_state_e       w_state_nx;
    logic            r_armed;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shreg;
    logic [7:0]      r_data;
    logic            r_val;
    logic [c_sw-1:0] r_stretch;
    logic            r_ferr;
    logic            w_clr;
    logic            w_half;
    logic            w_full;
    logic            w_start_ok;
    logic            w_shift;
    logic            w_good;
    logic            w_bad;

    uart_baud_cnt #(
        .DIV (DIV)
    ) u_baud_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_clr),
        .half_tick (w_half),
        .full_tick (w_full)
    );

    // Two-flop synchroniser on the asynchronous line, idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // Counts off the synchroniser fill so its reset value is never mistaken
    // for a genuinely idle line (otherwise a low line at reset release would
    // arm immediately and decode from mid-byte).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm <= 2'd0;
        end else if (r_warm != 2'd2) begin
            r_warm <= r_warm + 2'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic and sample-point strobes
    always_comb begin
        w_state_nx = r_state;
        w_clr      = 1'b0;
        w_start_ok = 1'b0;
        w_shift    = 1'b0;
        w_good     = 1'b0;
        w_bad      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Hold the bit timer at zero so START begins counting from 0
                w_clr = 1'b1;
                if (r_armed && !w_rxs) begin
                    w_state_nx = ST_START;
                end
            end
            ST_START: begin
                if (w_half) begin
                    w_clr = 1'b1;
                    if (w_rxs) begin
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_start_ok = 1'b1;
                        w_state_nx = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_full) begin
                    w_clr   = 1'b1;
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nx = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (w_full) begin
                    w_clr      = 1'b1;
                    w_state_nx = ST_IDLE;
                    if (w_rxs) begin
                        w_good = 1'b1;
                    end else begin
                        w_bad  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Arm on an idle-high line; a bad stop bit disarms until the line recovers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= 1'b0;
        end else if (w_bad) begin
            r_armed <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_rxs && (r_warm == 2'd2)) begin
            r_armed <= 1'b1;
        end
    end

    // Data bit counter and LSB-first shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= 3'd0;
            r_shreg   <= 8'd0;
        end else begin
            if (w_start_ok) begin
                r_bit_cnt <= 3'd0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_shift) begin
                r_shreg <= {w_rxs, r_shreg[7:1]};
            end
        end
    end

    // Output byte and sticky frame error, updated only at the stop sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= 8'd0;
            r_ferr <= 1'b0;
        end else if (w_good) begin
            r_data <= r_shreg;
            r_ferr <= 1'b0;
        end else if (w_bad) begin
            r_ferr <= 1'b1;
        end
    end

    // Valid stretcher: VAL_LEN cycles high per good frame, no retrigger
    always_ff @(posedge clk) begin
        if (rst) begin
            r_val     <= 1'b0;
            r_stretch <= '0;
        end else if (w_good && !r_val) begin
            r_val     <= 1'b1;
            r_stretch <= c_stretch_top;
        end else if (r_val) begin
            if (r_stretch == '0) begin
                r_val <= 1'b0;
            end else begin
                r_stretch <= r_stretch - c_sw'(1);
            end
        end
    end

    assign bus.iUART     = r_data;
    assign bus.ValRX     = r_val;
    assign bus.frame_err = r_ferr;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
// ============================================================================
// Module   : tb_uart_rx_byte
// Brief    : Scoreboard bench for uart_rx_byte at DIV=16, VAL_LEN=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_byte;

    localparam int CLK_HZ  = 1_000_000;
    localparam int BAUD    = 62_500;
    localparam int VAL_LEN = 4;
    localparam int BIT     = 16;
    localparam int LAT     = 155;   // 2 + 8 + 9*16 + 1

    typedef struct {
        logic [7:0] data;
        int         rise;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   ferr_rises = 0;
    exp_t exp_q[$];
    int   rise_log[$];

    logic mon_pv = 1'b0;
    logic mon_pf = 1'b0;
    int   mon_hl = 0;

    uart_rx_byte_if u_if ();

    uart_rx_byte #(
        .CLK_HZ  (CLK_HZ),
        .BAUD    (BAUD),
        .VAL_LEN (VAL_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One 8N1 frame; returns one cycle short of the stop-bit end so a
    // following call lands exactly back-to-back. rst_bit>=0 pulses reset
    // in the middle of that data bit (frame then expects no output).
    task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_bit);
        exp_t e;
        @(posedge clk);
        #1;
        if (stop && rst_bit < 0) begin
            e.data = b;
            e.rise = cyc + LAT;
            exp_q.push_back(e);
        end
        u_if.rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 u_if.rx = b[i];
            if (i == rst_bit) begin
                repeat (4) @(posedge clk);
                #1 rst = 1'b1;
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                repeat (BIT - 7) @(posedge clk);
            end else begin
                repeat (BIT) @(posedge clk);
            end
        end
        #1 u_if.rx = stop;
        repeat (BIT - 1) @(posedge clk);
    endtask

    // Monitor: pops the scoreboard on each ValRX rise, measures pulse width
    initial begin
        forever begin
            @(negedge clk);
            if (u_if.ValRX && !mon_pv) begin
                exp_t e;
                checks++;
                rise_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valrx actual=1 required=0 iUART=0x%02h (cycle %0d)",
                             u_if.iUART, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("iuart_at_valrx", u_if.iUART, e.data);
                    chk("valrx_rise_cycle", cyc, e.rise);
                    chk("ferr_at_valrx", u_if.frame_err, 1'b0);
                end
                mon_hl = 1;
            end else if (u_if.ValRX) begin
                mon_hl++;
            end else if (mon_pv) begin
                chk("valrx_high_cycles", mon_hl, VAL_LEN);
            end
            if (u_if.frame_err && !mon_pf) ferr_rises++;
            mon_pv = u_if.ValRX;
            mon_pf = u_if.frame_err;
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        int bc;
        u_if.rx = 1'b1;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_iuart", u_if.iUART, 8'h00);
        chk("rst_valrx", u_if.ValRX, 1'b0);
        chk("rst_ferr",  u_if.frame_err, 1'b0);
        chk("rst_busy",  u_if.busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);

        // Single byte from idle
        send_frame(8'h52, 1'b1, -1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("t1_iuart", u_if.iUART, 8'h52);
        chk("t1_ferr",  u_if.frame_err, 1'b0);

        // Back-to-back frames, one stop bit each
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("t2_iuart", u_if.iUART, 8'hFF);
        if (rise_log.size() >= 2)
            chk("t2_pulse_spacing", rise_log[rise_log.size()-1] - rise_log[rise_log.size()-2], 160);
        else
            chk("t2_pulse_count", rise_log.size(), 3);

        // Short glitch: 4 low cycles, start rejected at the half-bit check
        @(posedge clk);
        #1 u_if.rx = 1'b0;
        bc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (u_if.busy) bc++;
            if (i == 3) u_if.rx = 1'b1;
        end
        chk("t3_busy_cycles", bc, 8);
        chk("t3_iuart", u_if.iUART, 8'hFF);
        chk("t3_ferr",  u_if.frame_err, 1'b0);

        // Bad stop bit, then recovery
        send_frame(8'hA5, 1'b0, -1);
        repeat (10) @(posedge clk);
        #1 u_if.rx = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t4_ferr",       u_if.frame_err, 1'b1);
        chk("t4_iuart_kept", u_if.iUART, 8'hFF);
        chk("t4_ferr_rises", ferr_rises, 1);
        send_frame(8'h3C, 1'b1, -1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("t4b_iuart", u_if.iUART, 8'h3C);
        chk("t4b_ferr",  u_if.frame_err, 1'b0);

        // Reset during data bit 4 with the line low
        send_frame(8'h0F, 1'b1, 4);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("t5_iuart_reset", u_if.iUART, 8'h00);
        chk("t5_ferr",        u_if.frame_err, 1'b0);
        chk("t5_busy",        u_if.busy, 1'b0);
        send_frame(8'h81, 1'b1, -1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("t5b_iuart", u_if.iUART, 8'h81);

        // Break: line low for 40 bit times
        @(posedge clk);
        #1 u_if.rx = 1'b0;
        repeat (40 * BIT) @(posedge clk);
        #1 u_if.rx = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t6_ferr_rises", ferr_rises, 2);
        chk("t6_ferr",       u_if.frame_err, 1'b1);
        chk("t6_iuart_kept", u_if.iUART, 8'h81);
        send_frame(8'h55, 1'b1, -1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("t6b_iuart", u_if.iUART, 8'h55);
        chk("t6b_ferr",  u_if.frame_err, 1'b0);

        // Every expected byte must have been observed
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
